// File: rtl/d_imm_encoder.sv
// d_imm_encoder: expands a 32-bit constant load (li) into the shortest MIPS
// I-type sequence (ADDI, LUI, ORI, or LUI followed by ORI).
module d_imm_encoder #(
    parameter logic [5:0]  OPC_ADDI = 6'b001000,
    parameter logic [5:0]  OPC_LUI  = 6'b001111,
    parameter logic [5:0]  OPC_ORI  = 6'b001101,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_data_imm,
    input  logic [4:0]       i_data_rt,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_data_instr,
    output logic             o_last,
    output logic [CNT_W-1:0] o_cnt_split
);

    localparam int unsigned IMM_W = 16;
    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic [5:0]       opc;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [IMM_W-1:0] imm;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        HI     = 2'd2,
        LO     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    instr_t           instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             last_q,  last_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [IMM_W-1:0] lo_q,    lo_d;
    logic [REG_W-1:0] rt_q,    rt_d;

    logic [IMM_W-1:0] in_hi;
    logic [IMM_W-1:0] in_lo;
    logic             is_sext;
    logic             is_upper;
    logic             is_zext;

    // Classify the incoming constant; priority is applied in the FSM below
    always_comb begin
        in_hi    = i_data_imm[31:16];
        in_lo    = i_data_imm[15:0];
        is_sext  = (&i_data_imm[31:15]) | ~(|i_data_imm[31:15]);
        is_upper = ~(|in_lo);
        is_zext  = ~(|in_hi);
    end

    // Next-state and next-output logic; outputs are registered from these
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        last_d  = last_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        rt_d    = rt_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    rt_d    = i_data_rt;
                    lo_d    = in_lo;
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    if (is_sext) begin
                        instr_d = '{opc: OPC_ADDI, rs: '0, rt: i_data_rt, imm: in_lo};
                        last_d  = 1'b1;
                        state_d = SINGLE;
                    end else if (is_upper) begin
                        instr_d = '{opc: OPC_LUI, rs: '0, rt: i_data_rt, imm: in_hi};
                        last_d  = 1'b1;
                        state_d = SINGLE;
                    end else if (is_zext) begin
                        instr_d = '{opc: OPC_ORI, rs: '0, rt: i_data_rt, imm: in_lo};
                        last_d  = 1'b1;
                        state_d = SINGLE;
                    end else begin
                        instr_d = '{opc: OPC_LUI, rs: '0, rt: i_data_rt, imm: in_hi};
                        last_d  = 1'b0;
                        state_d = HI;
                    end
                end
            end
            HI: begin
                if (i_ready) begin
                    instr_d = '{opc: OPC_ORI, rs: rt_q, rt: rt_q, imm: lo_q};
                    last_d  = 1'b1;
                    state_d = LO;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            SINGLE, LO: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any expansion in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            instr_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
            lo_q    <= '0;
            rt_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            rt_q    <= rt_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_valid      = valid_q;
    assign o_last       = last_q;
    assign o_data_instr = instr_q;
    assign o_cnt_split  = cnt_q;

endmodule

// File: tb/tb_d_imm_encoder.sv
// Scoreboard bench for d_imm_encoder: directed constants with hand-encoded words.
module tb_d_imm_encoder;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data_imm;
    logic [4:0]  i_data_rt;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data_instr;
    logic        o_last;
    logic [15:0] o_cnt_split;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected beats: {last, instr}
    logic [32:0] exp_q[$];

    d_imm_encoder dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data_imm   (i_data_imm),
        .i_data_rt    (i_data_rt),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data_instr (o_data_instr),
        .o_last       (o_last),
        .o_cnt_split  (o_cnt_split)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each handshake must match the head of the scoreboard
    always @(negedge i_clk) begin
        logic [32:0] e;
        if (!i_rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got %h last %0b expected none", o_data_instr, o_last);
            end else begin
                e = exp_q.pop_front();
                check("beat_instr", o_data_instr, e[31:0]);
                check("beat_last", 32'(o_last), 32'(e[32]));
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!o_ready && k < 50) begin
            step();
            k++;
        end
        check("ready_timeout", 32'(o_ready), 32'd1);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || !o_ready) && k < 50) begin
            step();
            k++;
        end
        check("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send(input logic [31:0] imm, input logic [4:0] rt,
                        input logic [31:0] w0, input logic two, input logic [31:0] w1);
        wait_ready();
        i_valid    = 1'b1;
        i_data_imm = imm;
        i_data_rt  = rt;
        exp_q.push_back({~two, w0});
        if (two) exp_q.push_back({1'b1, w1});
        step();
        i_valid = 1'b0;
        drain();
    endtask

    initial begin
        i_rst      = 1'b1;
        i_valid    = 1'b0;
        i_ready    = 1'b1;
        i_data_imm = '0;
        i_data_rt  = '0;
        step();
        step();
        i_rst = 1'b0;

        // Reset state
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_last",  32'(o_last),  32'd0);
        check("rst_instr", o_data_instr, 32'h0);
        check("rst_cnt",   32'(o_cnt_split), 32'd0);

        // T1..T4 and boundary constants
        send(32'hFFFF_8000, 5'd8,  32'h2008_8000, 1'b0, 32'h0);
        check("t1_cnt", 32'(o_cnt_split), 32'd0);
        send(32'h1234_0000, 5'd9,  32'h3C09_1234, 1'b0, 32'h0);
        send(32'h0000_8001, 5'd10, 32'h340A_8001, 1'b0, 32'h0);
        send(32'h1234_5678, 5'd11, 32'h3C0B_1234, 1'b1, 32'h356B_5678);
        check("t4_cnt", 32'(o_cnt_split), 32'd1);
        send(32'h0000_0000, 5'd3,  32'h2003_0000, 1'b0, 32'h0);
        send(32'h0000_7FFF, 5'd1,  32'h2001_7FFF, 1'b0, 32'h0);
        send(32'hFFFF_FFFF, 5'd2,  32'h2002_FFFF, 1'b0, 32'h0);
        send(32'h8000_0000, 5'd31, 32'h3C1F_8000, 1'b0, 32'h0);
        send(32'h0001_0000, 5'd4,  32'h3C04_0001, 1'b0, 32'h0);
        send(32'h0000_FFFF, 5'd5,  32'h3405_FFFF, 1'b0, 32'h0);
        send(32'h0001_8000, 5'd0,  32'h3C00_0001, 1'b1, 32'h3400_8000);
        check("split2_cnt", 32'(o_cnt_split), 32'd2);

        // T5: downstream stalls in HI while a new request is held on the input
        wait_ready();
        i_ready    = 1'b0;
        i_valid    = 1'b1;
        i_data_imm = 32'h1234_5678;
        i_data_rt  = 5'd11;
        exp_q.push_back({1'b0, 32'h3C0B_1234});
        exp_q.push_back({1'b1, 32'h356B_5678});
        step();
        i_data_imm = 32'h0000_0000;
        i_data_rt  = 5'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("t5_hold_instr", o_data_instr, 32'h3C0B_1234);
            check("t5_hold_last",  32'(o_last),  32'd0);
            check("t5_hold_valid", 32'(o_valid), 32'd1);
            check("t5_hold_ready", 32'(o_ready), 32'd0);
        end
        step();
        i_valid = 1'b0;
        i_ready = 1'b1;
        drain();
        check("t5_cnt", 32'(o_cnt_split), 32'd3);

        // T6: reset while the ORI beat is pending
        wait_ready();
        i_valid    = 1'b1;
        i_data_imm = 32'h1234_5678;
        i_data_rt  = 5'd12;
        exp_q.push_back({1'b0, 32'h3C0C_1234});
        step();
        i_valid = 1'b0;
        step();
        i_ready = 1'b0;
        check("t6_lo_instr", o_data_instr, 32'h358C_5678);
        check("t6_lo_last",  32'(o_last),  32'd1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_ready = 1'b1;
        check("t6_valid", 32'(o_valid), 32'd0);
        check("t6_ready", 32'(o_ready), 32'd1);
        check("t6_cnt",   32'(o_cnt_split), 32'd0);
        check("t6_last",  32'(o_last), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check("t6_no_ori", 32'(o_valid), 32'd0);
        check("t6_queue",  32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
